// File: rtl/inv_add_round_key_if.sv
// Bus bundle for inv_add_round_key: key store write port, input and output
// valid/ready beat channels, and the sticky error flag.
// master = upstream/downstream driver side, slave = the AddRoundKey stage.
interface inv_add_round_key_if;
  // key store write port
  logic         key_we;
  logic [3:0]   key_addr;
  logic [127:0] key_wdata;
  // input beat channel
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [127:0] in_data;
  // output beat channel
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_round;
  logic         out_last;
  // sticky protocol error
  logic         err;

  modport master (
    output key_we, key_addr, key_wdata,
    output in_valid, in_first, in_data,
    input  in_ready,
    input  out_valid, out_data, out_round, out_last,
    output out_ready,
    input  err
  );

  modport slave (
    input  key_we, key_addr, key_wdata,
    input  in_valid, in_first, in_data,
    output in_ready,
    output out_valid, out_data, out_round, out_last,
    input  out_ready,
    output err
  );
endinterface

// File: rtl/inv_add_round_key.sv
// AES inverse-cipher AddRoundKey stage: XORs each state beat with the round key
// chosen by a per-block round counter; key schedule held in a local key store.
// Latency 1 cycle; in_ready = !out_valid || out_ready (full throughput, stalls
// only while a registered output beat is held by downstream).
// Ports: clk, rst (async active-low), bus (inv_add_round_key_if.slave:
// key write port, in_* beat channel, out_* beat channel, sticky err).
// Optional macro INV_ARK_ZEROIZE_EN: key store resets to zero and is wiped
// when the out_last beat is taken downstream.
module inv_add_round_key #(
  parameter int NR = 10
) (
  input  logic               clk,
  input  logic               rst,
  inv_add_round_key_if.slave bus
);

  localparam logic [3:0] LP_NR    = 4'(NR);
  localparam logic [3:0] LP_NR_M1 = 4'(NR - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_rc, w_rc_nxt;
  logic [127:0] r_key [0:NR];

  logic         r_out_valid;
  logic [127:0] r_out_data;
  logic [3:0]   r_out_round;
  logic         r_out_last;
  logic         r_err;

  logic         w_in_ready;
  logic         w_accept;
  logic [3:0]   w_sel;
  logic         w_emit;
  logic         w_last;
  logic         w_err_set;
  logic [127:0] w_key;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  // Read sees the pre-write contents, so a same-cycle write lands next cycle.
  assign w_key      = r_key[w_sel];

  // Key store
`ifdef INV_ARK_ZEROIZE_EN
  logic w_zeroize;
  assign w_zeroize = r_out_valid && bus.out_ready && r_out_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= NR; i++) r_key[i] <= '0;
    end else if (w_zeroize) begin
      for (int i = 0; i <= NR; i++) r_key[i] <= '0;
    end else if (bus.key_we && (bus.key_addr <= LP_NR)) begin
      r_key[bus.key_addr] <= bus.key_wdata;
    end
  end
`else
  // No reset so the store can map onto RAM.
  always_ff @(posedge clk) begin
    if (bus.key_we && (bus.key_addr <= LP_NR)) begin
      r_key[bus.key_addr] <= bus.key_wdata;
    end
  end
`endif

  // Round FSM: next state, key select, output enable
  always_comb begin
    w_state_nxt = r_state;
    w_rc_nxt    = r_rc;
    w_sel       = LP_NR;
    w_emit      = 1'b0;
    w_last      = 1'b0;
    w_err_set   = 1'b0;
    if (w_accept) begin
      if (bus.in_first) begin
        // A new block start; abandoning an open block is an error.
        if (r_state == ACTIVE) w_err_set = 1'b1;
        w_sel       = LP_NR;
        w_rc_nxt    = LP_NR_M1;
        w_state_nxt = ACTIVE;
        w_emit      = 1'b1;
      end else if (r_state == IDLE) begin
        // Mid-block beat with no block open: dropped.
        w_err_set = 1'b1;
      end else begin
        w_sel  = r_rc;
        w_emit = 1'b1;
        if (r_rc == 4'd0) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_rc_nxt = r_rc - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rc    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rc    <= w_rc_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Registered output stage; payload only changes when a new beat is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_round <= '0;
      r_out_last  <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data ^ w_key;
      r_out_round <= w_sel;
      r_out_last  <= w_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_round = r_out_round;
  assign bus.out_last  = r_out_last;
  assign bus.err       = r_err;

endmodule
